// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Register-file indexing and write-back entry layout.
package cpu_pkg;

    localparam int REG_COUNT = 16;
    localparam int ADDR_W    = $clog2(REG_COUNT);
    localparam int DATA_W    = 32;

    localparam logic [3:0] PC_INDEX = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue for register write-back.
// Exposes its storage so the top can search pending writes.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int W     = ADDR_W + DATA_W,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          rdata,
    output logic [PW-1:0]         head,
    output logic [CW-1:0]         count,
    output logic [DEPTH-1:0][W-1:0] entries
);

    logic [PW-1:0] tail;

    assign rdata = entries[head];

    // Entry storage; validity is tracked by head/count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entries[tail] <= wdata;
        end
    end

    // Pointers and occupancy; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back queue feeding the register-file write port.
// Steers R15 results to the PC and forwards pending writes to readers.
module regfile_writeback_queue
    import cpu_pkg::*;
#(
    parameter int N     = ADDR_W,
    parameter int M     = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_addr,
    input  logic [M-1:0]             in_data,
    input  logic                     port_free,
    input  logic                     flush,
    output logic                     WE3,
    output logic [N-1:0]             A3,
    output logic [M-1:0]             WD3,
    output logic                     pc_we,
    output logic [M-1:0]             pc_data,
    input  logic [N-1:0]             A1,
    input  logic [N-1:0]             A2,
    output logic                     fwd1_hit,
    output logic [M-1:0]             fwd1_data,
    output logic                     fwd2_hit,
    output logic [M-1:0]             fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int W  = N + M;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [N-1:0] PC_IDX = N'(PC_INDEX);

    logic                    push;
    logic                    pop;
    logic [W-1:0]            head_entry;
    logic [N-1:0]            head_addr;
    logic [M-1:0]            head_data;
    logic [PW-1:0]           head;
    logic [DEPTH-1:0][W-1:0] entries;

    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = (count != '0) && port_free && !flush;
    assign head_addr = head_entry[W-1:M];
    assign head_data = head_entry[M-1:0];

    wb_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   ({in_addr, in_data}),
        .rdata   (head_entry),
        .head    (head),
        .count   (count),
        .entries (entries)
    );

    // Output stage: retire the head to the write port or to the PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WE3     <= 1'b0;
            A3      <= '0;
            WD3     <= '0;
            pc_we   <= 1'b0;
            pc_data <= '0;
        end else begin
            WE3   <= 1'b0;
            pc_we <= 1'b0;
            if (pop) begin
                if (head_addr == PC_IDX) begin
                    pc_we   <= 1'b1;
                    pc_data <= head_data;
                end else begin
                    WE3 <= 1'b1;
                    A3  <= head_addr;
                    WD3 <= head_data;
                end
            end
        end
    end

    // Youngest match wins: output stage first, then queue oldest-to-newest.
    function automatic logic [M:0] lookup(input logic [N-1:0] ra);
        logic [M:0]    r;
        logic [PW-1:0] idx;
        logic [W-1:0]  e;
        r = '0;
        if (ra != PC_IDX) begin
            if (WE3 && A3 == ra) r = {1'b1, WD3};
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                e   = entries[idx];
                if (CW'(i) < count && e[W-1:M] == ra) begin
                    r = {1'b1, e[M-1:0]};
                end
            end
        end
        return r;
    endfunction

    // Bypass lookups for both read ports.
    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(A1);
        {fwd2_hit, fwd2_data} = lookup(A2);
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue.
// Hand-computed expectations, one checking task.
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_addr;
    logic [31:0] in_data;
    logic        port_free;
    logic        flush;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        pc_we;
    logic [31:0] pc_data;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    int vectors = 0;
    int errors  = 0;

    regfile_writeback_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .port_free (port_free),
        .flush     (flush),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .pc_we     (pc_we),
        .pc_data   (pc_data),
        .A1        (A1),
        .A2        (A2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    logic [31:0] exp_d [4];

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        port_free = 1'b1;
        flush     = 1'b0;
        A1        = 4'd0;
        A2        = 4'd0;
        exp_d     = '{32'h11, 32'h22, 32'h33, 32'h44};

        // Reset state
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_we3", 64'(WE3), 64'd0);
        chk("rst_a3", 64'(A3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_pcwe", 64'(pc_we), 64'd0);
        chk("rst_pcdata", 64'(pc_data), 64'd0);
        chk("rst_fwd1", 64'(fwd1_hit), 64'd0);
        reset = 1'b1;
        step();
        chk("rst_ready", 64'(in_ready), 64'd1);

        // 1: single push, two-cycle latency
        offer(4'd3, 32'hDEADBEEF);
        A1 = 4'd3;
        step();
        in_valid = 1'b0;
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_we3_lo", 64'(WE3), 64'd0);
        chk("t1_fwdq_hit", 64'(fwd1_hit), 64'd1);
        chk("t1_fwdq_dat", 64'(fwd1_data), 64'hDEADBEEF);
        step();
        chk("t1_we3", 64'(WE3), 64'd1);
        chk("t1_a3", 64'(A3), 64'd3);
        chk("t1_wd3", 64'(WD3), 64'hDEADBEEF);
        chk("t1_count0", 64'(count), 64'd0);
        chk("t1_fwdo_hit", 64'(fwd1_hit), 64'd1);
        step();
        chk("t1_we3_off", 64'(WE3), 64'd0);
        chk("t1_fwd_gone", 64'(fwd1_hit), 64'd0);

        // 2: fill, full, youngest forward, drain in order
        port_free = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(4'd5, exp_d[i]);
            step();
        end
        chk("t2_count4", 64'(count), 64'd4);
        chk("t2_ready0", 64'(in_ready), 64'd0);
        offer(4'd5, 32'h55);
        step();
        in_valid = 1'b0;
        chk("t2_count_hold", 64'(count), 64'd4);
        A1 = 4'd5;
        A2 = 4'd5;
        #1;
        chk("t2_fwd1_hit", 64'(fwd1_hit), 64'd1);
        chk("t2_fwd1_dat", 64'(fwd1_data), 64'h44);
        chk("t2_fwd2_dat", 64'(fwd2_data), 64'h44);
        port_free = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_drain_we", 64'(WE3), 64'd1);
            chk("t2_drain_wd", 64'(WD3), 64'(exp_d[i]));
            chk("t2_drain_cnt", 64'(count), 64'(3 - i));
        end
        chk("t2_last_fwd", 64'(fwd1_data), 64'h44);
        step();
        chk("t2_no_55", 64'(WE3), 64'd0);

        // 3: R15 goes to the PC path
        offer(4'd15, 32'h100);
        A1 = 4'd15;
        step();
        in_valid = 1'b0;
        chk("t3_fwd15", 64'(fwd1_hit), 64'd0);
        step();
        chk("t3_pcwe", 64'(pc_we), 64'd1);
        chk("t3_pcdata", 64'(pc_data), 64'h100);
        chk("t3_we3", 64'(WE3), 64'd0);
        chk("t3_fwd15b", 64'(fwd1_hit), 64'd0);
        step();
        chk("t3_pcwe_off", 64'(pc_we), 64'd0);

        // 4: simultaneous push and pop at count=2
        port_free = 1'b0;
        offer(4'd1, 32'hA1);
        step();
        offer(4'd2, 32'hA2);
        step();
        chk("t4_count2", 64'(count), 64'd2);
        port_free = 1'b1;
        offer(4'd3, 32'hA3);
        step();
        in_valid = 1'b0;
        chk("t4_count_same", 64'(count), 64'd2);
        chk("t4_ready", 64'(in_ready), 64'd1);
        chk("t4_a3_1", 64'(A3), 64'd1);
        chk("t4_wd_1", 64'(WD3), 64'hA1);
        step();
        chk("t4_wd_2", 64'(WD3), 64'hA2);
        chk("t4_a3_2", 64'(A3), 64'd2);
        step();
        chk("t4_wd_3", 64'(WD3), 64'hA3);
        chk("t4_count0", 64'(count), 64'd0);
        step();

        // 5: flush beats a simultaneous push
        port_free = 1'b0;
        offer(4'd6, 32'h66);
        step();
        offer(4'd7, 32'h77);
        step();
        offer(4'd8, 32'h88);
        step();
        chk("t5_count3", 64'(count), 64'd3);
        offer(4'd9, 32'h99);
        flush = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        port_free = 1'b1;
        A1 = 4'd9;
        #1;
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_we3", 64'(WE3), 64'd0);
        chk("t5_fwd9", 64'(fwd1_hit), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_write", 64'(WE3), 64'd0);
        end

        // 6: asynchronous reset mid-drain
        offer(4'd4, 32'h4444);
        step();
        offer(4'd5, 32'h5555);
        step();
        in_valid = 1'b0;
        chk("t6_we3_pre", 64'(WE3), 64'd1);
        chk("t6_count_pre", 64'(count), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_we3_async", 64'(WE3), 64'd0);
        chk("t6_count_async", 64'(count), 64'd0);
        chk("t6_pcwe_async", 64'(pc_we), 64'd0);
        #1;
        reset = 1'b1;
        step();
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_we3_after", 64'(WE3), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side producer for the 16-entry CPU register file: accepts completed results (destination index and data) from the execute and memory stages through a valid/ready handshake.
- Buffers the results in a small in-order queue and drains them one per cycle onto the single register-file write port (WE3/A3/WD3).
- Writes to R15 go to a PC-redirect output instead of the write port.
- Supplies bypass data to the two read ports (A1/A2) so that reads never see stale values while writes are pending.

Parameters:
- N, 4, register index width
- M, 32, data width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  producer offers a result
- in_ready  out  1  queue can accept; transfer when in_valid & in_ready
- in_addr  in  N  destination register index
- in_data  in  M  result value
- port_free  in  1  register-file write port available this cycle
- flush  in  1  discard all queued and in-flight results
- WE3  out  1  register-file write enable (registered)
- A3  out  N  register-file write address (registered)
- WD3  out  M  register-file write data (registered)
- pc_we  out  1  one-cycle pulse: R15 result retired (registered)
- pc_data  out  M  R15 value, valid while pc_we=1
- A1  in  N  read address, port 1
- A2  in  N  read address, port 2
- fwd1_hit  out  1  a pending write targets A1
- fwd1_data  out  M  youngest pending value for A1
- fwd2_hit  out  1  same as fwd1_hit, for A2
- fwd2_data  out  M  same as fwd1_data, for A2
- count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0; queue pointers = 0.
  - WE3=0, A3=0, WD3=0, pc_we=0, pc_data=0.
  - in_ready=1 after release; fwd*_hit=0.
- Push: in_valid & in_ready at edge t writes {in_addr, in_data} at the tail; count increments.
- in_ready = (count < DEPTH), combinational from count only. A push and a pop in the same edge are legal whenever count < DEPTH; count is then unchanged.
- Pop: at an edge where count>0 and port_free=1, the head entry retires and count decrements.
  - Head addr ≠ 15: next cycle WE3=1, A3=addr, WD3=data, pc_we=0.
  - Head addr = 15: next cycle pc_we=1, pc_data=data, WE3=0.
- If no pop occurs at an edge, WE3 and pc_we are 0 for the following cycle. A3/WD3 hold their last values.
- Latency, empty queue, port_free=1:
  - push at edge t, pop at edge t+1, WE3=1 during cycle t+1..t+2;
  - the register file captures the value at edge t+2.
- Ordering: strictly FIFO. Multiple entries to the same register retire in push order.
- Forwarding is combinational. For port k (A1→1, A2→2), candidates are all valid queue entries plus the output stage while WE3=1.
  - Youngest match wins: newest queue entry, then older entries, then the output stage.
  - fwdk_hit=1 with fwdk_data = matched value; otherwise fwdk_hit=0 and fwdk_data=0.
  - Index 15 never hits; the PC path is separate.
- Flush (synchronous, sampled at edge):
  - count→0, pointers→0;
  - WE3 and pc_we forced to 0 the next cycle;
  - a simultaneous push is dropped;
  - flush has priority over push and pop.
- Full: in_ready=0. in_valid with in_ready=0 is ignored; the producer must hold its offer.
- Pointer wrap: tail and head wrap modulo DEPTH; count distinguishes full from empty.
- Reset asserted mid-drain: all state is cleared immediately; the pending write is lost and WE3 drops asynchronously.

Decomposition:
- Shared package cpu_pkg:
  - constant PC_INDEX = 4'd15;
  - typedef wb_entry_t (struct: addr[N-1:0], data[M-1:0]);
  - REG_COUNT = 16.
- One natural sub-module: wb_fifo (parameterised storage, pointers, count, push/pop/flush).
- The top level holds the output register stage, the R15 steering, and the two forwarding comparators.

Test Plan:
1. Reset then single push (addr=3, data=0xDEADBEEF) with port_free=1 → two cycles later WE3=1, A3=3, WD3=0xDEADBEEF for exactly one cycle; count returns to 0.
2. port_free=0, push addr 5 = 0x11, 0x22, 0x33, 0x44 → count=4, in_ready=0; a fifth push (0x55) is ignored. With A1=5: fwd1_hit=1, fwd1_data=0x44. Raise port_free → WE3 writes 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
3. Push addr=15, data=0x00000100 → pc_we=1, pc_data=0x100 for one cycle; WE3 stays 0; A1=15 gives fwd1_hit=0.
4. Queue at count=2 with push and pop on the same edge → count stays 2, in_ready stays 1, order preserved.
5. Queue holds 3 entries and flush=1 coincides with in_valid=1 → next cycle count=0, WE3=0, the pushed entry never appears on WE3.
6. Drive reset=0 mid-cycle while WE3=1 → WE3, pc_we, and count go to 0 immediately, without waiting for a clock edge.
